// File: rtl/pipeline_debug_ctrl.sv
// pipeline_debug_ctrl: run/step/halt sequencing and register dump
// for the five-stage pipeline.
//
// Ports:
//   i_clk, i_reset (async, active-low)
//   i_cmd_valid/i_cmd/o_cmd_ready : host command channel
//   i_halt                        : halt seen in decode
//   o_pipe_en                     : PC / pipe-reg / RF-write enable
//   o_dbg_sel/o_dbg_reg_addr      : RF read port 1 takeover
//   i_reg_data                    : RF read port 1 data
//   o_dump_*/i_dump_ready         : register dump stream
//   o_done                        : STEP/DUMP completion pulse
//   o_cycle_count, o_state        : status
module pipeline_debug_ctrl #(
  parameter int N_BITS     = 32,
  parameter int N_REG_BITS = 5,
  parameter int N_REGS     = 32
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_cmd_valid,
  input  logic [1:0]            i_cmd,
  output logic                  o_cmd_ready,
  input  logic                  i_halt,
  output logic                  o_pipe_en,
  output logic                  o_dbg_sel,
  output logic [N_REG_BITS-1:0] o_dbg_reg_addr,
  input  logic [N_BITS-1:0]     i_reg_data,
  output logic                  o_dump_valid,
  output logic [N_REG_BITS-1:0] o_dump_addr,
  output logic [N_BITS-1:0]     o_dump_data,
  input  logic                  i_dump_ready,
  output logic                  o_done,
  output logic [N_BITS-1:0]     o_cycle_count,
  output logic [2:0]            o_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RUN  = 3'd1,
    S_STEP = 3'd2,
    S_DUMP = 3'd3,
    S_HALT = 3'd4
  } state_t;

  localparam logic [1:0] C_RUN  = 2'b00;
  localparam logic [1:0] C_STEP = 2'b01;
  localparam logic [1:0] C_DUMP = 2'b10;
  localparam logic [1:0] C_STOP = 2'b11;

  localparam logic [N_REG_BITS-1:0] LAST =
    N_REG_BITS'(N_REGS - 1);

  state_t                state_q;
  logic                  ret_halt_q;
  logic [N_REG_BITS-1:0] addr_q;
  logic [N_BITS-1:0]     cnt_q;
  logic                  done_q;

  logic acc;
  logic stop_acc;
  logic hs;

  always_comb begin
    o_cmd_ready = 1'b0;
    unique case (state_q)
      S_IDLE, S_RUN, S_HALT: o_cmd_ready = 1'b1;
      default:               o_cmd_ready = 1'b0;
    endcase
  end

  assign acc      = i_cmd_valid & o_cmd_ready;
  assign stop_acc = acc & (i_cmd == C_STOP);

  always_comb begin
    o_pipe_en = 1'b0;
    unique case (state_q)
      S_RUN:   o_pipe_en = ~i_halt & ~stop_acc;
      S_STEP:  o_pipe_en = ~i_halt;
      default: o_pipe_en = 1'b0;
    endcase
  end

  assign o_dbg_sel      = (state_q == S_DUMP);
  assign o_dbg_reg_addr = addr_q;
  assign o_dump_valid   = o_dbg_sel;
  assign o_dump_addr    = addr_q;
  assign o_dump_data    = i_reg_data;
  assign hs             = o_dump_valid & i_dump_ready;

  assign o_done        = done_q;
  assign o_cycle_count = cnt_q;
  assign o_state       = state_q;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= S_IDLE;
      ret_halt_q <= 1'b0;
      addr_q     <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (acc) begin
            unique case (i_cmd)
              C_RUN:  state_q <= S_RUN;
              C_STEP: state_q <= S_STEP;
              C_DUMP: begin
                state_q    <= S_DUMP;
                ret_halt_q <= 1'b0;
              end
              default: state_q <= S_IDLE;
            endcase
          end
        end
        S_RUN: begin
          // halt wins over a same-cycle STOP
          if (i_halt)        state_q <= S_HALT;
          else if (stop_acc) state_q <= S_IDLE;
        end
        S_STEP: begin
          done_q  <= 1'b1;
          state_q <= i_halt ? S_HALT : S_IDLE;
        end
        S_DUMP: begin
          if (hs) begin
            if (addr_q == LAST) begin
              addr_q  <= '0;
              done_q  <= 1'b1;
              state_q <= ret_halt_q ? S_HALT : S_IDLE;
            end else begin
              addr_q <= addr_q + 1'b1;
            end
          end
        end
        S_HALT: begin
          if (acc && i_cmd == C_DUMP) begin
            state_q    <= S_DUMP;
            ret_halt_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // saturating count of advancing cycles
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      cnt_q <= '0;
    end else if (o_pipe_en && cnt_q != '1) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_debug_ctrl.sv
// tb_pipeline_debug_ctrl: scoreboard bench for the
// pipeline sequencing / dump controller.
module tb_pipeline_debug_ctrl;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic [1:0]  cmd;
  logic        cmd_ready;
  logic        halt;
  logic        pipe_en;
  logic        dbg_sel;
  logic [4:0]  dbg_addr;
  logic [31:0] reg_data;
  logic        dump_valid;
  logic [4:0]  dump_addr;
  logic [31:0] dump_data;
  logic        dump_ready;
  logic        done;
  logic [31:0] cycle_count;
  logic [2:0]  state;

  pipeline_debug_ctrl dut (
    .i_clk          (clk),
    .i_reset        (rst_n),
    .i_cmd_valid    (cmd_valid),
    .i_cmd          (cmd),
    .o_cmd_ready    (cmd_ready),
    .i_halt         (halt),
    .o_pipe_en      (pipe_en),
    .o_dbg_sel      (dbg_sel),
    .o_dbg_reg_addr (dbg_addr),
    .i_reg_data     (reg_data),
    .o_dump_valid   (dump_valid),
    .o_dump_addr    (dump_addr),
    .o_dump_data    (dump_data),
    .i_dump_ready   (dump_ready),
    .o_done         (done),
    .o_cycle_count  (cycle_count),
    .o_state        (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // register file model: read port 1 value per address
  assign reg_data = 32'hA000_0000 + {27'b0, dbg_addr};

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } word_t;

  word_t      dq[$];
  logic [2:0] doneq[$];

  int n_vec = 0;
  int n_err = 0;
  int n_done = 0;
  int pe_bad = 0;

  logic        stalled = 1'b0;
  logic [4:0]  st_a;
  logic [31:0] st_d;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // monitor: pops expectations whenever the DUT presents output
  always @(negedge clk) begin
    if (rst_n) begin
      if (state == 3'd3 && pipe_en) pe_bad++;
      if (dump_valid && stalled) begin
        chk("stall_addr", {27'b0, dump_addr}, {27'b0, st_a});
        chk("stall_data", dump_data, st_d);
      end
      stalled = dump_valid && !dump_ready;
      st_a    = dump_addr;
      st_d    = dump_data;
      if (dump_valid && dump_ready) begin
        if (dq.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL dump_extra: got addr %0d expected none",
                   dump_addr);
        end else begin
          word_t w;
          w = dq.pop_front();
          chk("dump_addr", {27'b0, dump_addr}, {27'b0, w.a});
          chk("dump_data", dump_data, w.d);
        end
      end
      if (done) begin
        n_done++;
        if (doneq.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL done_extra: got pulse expected none");
        end else begin
          logic [2:0] es;
          es = doneq.pop_front();
          chk("done_state", {29'b0, state}, {29'b0, es});
        end
      end
    end else begin
      stalled = 1'b0;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] c);
    cmd_valid = 1'b1;
    cmd       = c;
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int d0;
    rst_n      = 1'b0;
    cmd_valid  = 1'b0;
    cmd        = 2'b00;
    halt       = 1'b0;
    dump_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // async reset with no clock edge
    send(2'b00);
    repeat (3) tick();
    chk("pre_rst_state", {29'b0, state}, 32'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_state", {29'b0, state}, 32'd0);
    chk("rst_ready", {31'b0, cmd_ready}, 32'd1);
    chk("rst_pipe_en", {31'b0, pipe_en}, 32'd0);
    chk("rst_dbg_sel", {31'b0, dbg_sel}, 32'd0);
    chk("rst_dbg_addr", {27'b0, dbg_addr}, 32'd0);
    chk("rst_dump_valid", {31'b0, dump_valid}, 32'd0);
    chk("rst_dump_addr", {27'b0, dump_addr}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_count", cycle_count, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // run then halt
    send(2'b00);
    chk("run_pipe_en", {31'b0, pipe_en}, 32'd1);
    repeat (10) tick();
    halt = 1'b1;
    #1;
    chk("halt_pipe_en", {31'b0, pipe_en}, 32'd0);
    tick();
    halt = 1'b0;
    chk("halt_state", {29'b0, state}, 32'd4);
    chk("halt_count", cycle_count, 32'd10);
    send(2'b00);
    chk("halt_run_ign", {29'b0, state}, 32'd4);
    chk("halt_run_cnt", cycle_count, 32'd10);

    // dump from HALTED with alternating ready
    for (int i = 0; i < 32; i++)
      dq.push_back('{a: 5'(i), d: 32'hA000_0000 + 32'(i)});
    doneq.push_back(3'd4);
    d0 = n_done;
    send(2'b10);
    chk("dump_ready_lo", {31'b0, cmd_ready}, 32'd0);
    for (int k = 0; k < 200 && n_done == d0; k++) begin
      dump_ready = (k % 2 == 0);
      tick();
    end
    dump_ready = 1'b0;
    chk("dump_done", 32'(n_done - d0), 32'd1);
    chk("dump_ret", {29'b0, state}, 32'd4);
    chk("dump_count", cycle_count, 32'd10);
    chk("dump_left", 32'(dq.size()), 32'd0);
    chk("dump_pipe_en", 32'(pe_bad), 32'd0);

    // step x3 from IDLE
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("step_init", {29'b0, state}, 32'd0);
    for (int s = 0; s < 3; s++) begin
      doneq.push_back(3'd0);
      d0 = n_done;
      send(2'b01);
      chk("step_ready", {31'b0, cmd_ready}, 32'd0);
      chk("step_pipe_en", {31'b0, pipe_en}, 32'd1);
      chk("step_state", {29'b0, state}, 32'd2);
      for (int k = 0; k < 5 && n_done == d0; k++) tick();
      chk("step_done", 32'(n_done - d0), 32'd1);
      chk("step_count", cycle_count, 32'(s + 1));
    end

    // plain STOP in RUN
    send(2'b00);
    tick();
    cmd_valid = 1'b1;
    cmd       = 2'b11;
    #1;
    chk("stop_pipe_en", {31'b0, pipe_en}, 32'd0);
    tick();
    cmd_valid = 1'b0;
    chk("stop_state", {29'b0, state}, 32'd0);
    chk("stop_count", cycle_count, 32'd4);

    // STOP with simultaneous halt
    send(2'b00);
    cmd_valid = 1'b1;
    cmd       = 2'b11;
    halt      = 1'b1;
    #1;
    chk("sh_ready", {31'b0, cmd_ready}, 32'd1);
    chk("sh_pipe_en", {31'b0, pipe_en}, 32'd0);
    tick();
    cmd_valid = 1'b0;
    halt      = 1'b0;
    chk("sh_state", {29'b0, state}, 32'd4);
    chk("sh_count", cycle_count, 32'd4);

    // reset mid-dump at addr 7
    for (int i = 0; i < 7; i++)
      dq.push_back('{a: 5'(i), d: 32'hA000_0000 + 32'(i)});
    dump_ready = 1'b1;
    send(2'b10);
    for (int k = 0; k < 50 && dbg_addr != 5'd7; k++) tick();
    chk("abort_at7", {27'b0, dbg_addr}, 32'd7);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_state", {29'b0, state}, 32'd0);
    chk("abort_dbg_sel", {31'b0, dbg_sel}, 32'd0);
    chk("abort_addr", {27'b0, dbg_addr}, 32'd0);
    chk("abort_done", {31'b0, done}, 32'd0);
    d0 = n_done;
    dump_ready = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (5) tick();
    chk("abort_no_done", 32'(n_done - d0), 32'd0);
    chk("abort_left", 32'(dq.size()), 32'd0);
    chk("done_left", 32'(doneq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipeline_debug_ctrl.md
# pipeline_debug_ctrl

Sequencing controller for the five-stage MIPS pipeline. It decides on which cycles the pipeline advances: free-run, single-step, or frozen after `halt`. It also takes over register-file read port 1 from instruction decode to stream all registers out over a valid/ready channel for the host debug link. It sits between the host command interface and the pipeline-register, PC and register-file enables.

## Interface
Parameters:
- `N_BITS`, 32, register data width.
- `N_REG_BITS`, 5, register address width.
- `N_REGS`, 32, number of registers dumped; must be ≤ 2^N_REG_BITS.

Ports:
- `i_clk`  in  1  single clock; all state updates on the rising edge.
- `i_reset`  in  1  reset, asynchronous, active-low.
- `i_cmd_valid`  in  1  command present.
- `i_cmd`  in  2  command code:
  - 00 RUN
  - 01 STEP
  - 10 DUMP
  - 11 STOP
- `o_cmd_ready`  out  1  controller accepts a command this cycle.
- `i_halt`  in  1  halt instruction detected in decode (combinational from decode).
- `o_pipe_en`  out  1  pipeline advances this cycle. It gates the PC, all pipeline registers and the register-file write enable.
- `o_dbg_sel`  out  1  when 1, register-file read port 1 address is `o_dbg_reg_addr` instead of the instruction rs field.
- `o_dbg_reg_addr`  out  N_REG_BITS  debug read address.
- `i_reg_data`  in  N_BITS  register-file read port 1 data (combinational read).
- `o_dump_valid`  out  1  dump word valid.
- `o_dump_addr`  out  N_REG_BITS  register index of the dump word.
- `o_dump_data`  out  N_BITS  dump word; equals `i_reg_data`.
- `i_dump_ready`  in  1  sink accepts the dump word.
- `o_done`  out  1  one-cycle pulse when a STEP or DUMP completes.
- `o_cycle_count`  out  N_BITS  number of cycles with `o_pipe_en`=1.
- `o_state`  out  3  current state encoding:
  - IDLE=0
  - RUN=1
  - STEP=2
  - DUMP=3
  - HALTED=4

## Operation
- **Command acceptance.** A command is accepted when `i_cmd_valid` and `o_cmd_ready` are both 1. `o_cmd_ready` is 1 in IDLE, RUN and HALTED, and 0 in STEP and DUMP.
- **IDLE.** `o_pipe_en`=0.
  - RUN goes to RUN.
  - STEP goes to STEP.
  - DUMP goes to DUMP and records IDLE as the return state.
  - STOP has no effect.
- **RUN.** `o_pipe_en` = ~`i_halt` & ~(accepted STOP).
  - If `i_halt`=1, the next state is HALTED. Halt has priority over a simultaneous STOP.
  - An accepted STOP goes to IDLE.
  - RUN, STEP and DUMP commands received in RUN are accepted and ignored.
- **STEP.** Lasts exactly one cycle.
  - `o_pipe_en` = ~`i_halt`.
  - The next state is HALTED if `i_halt`=1, otherwise IDLE.
  - `o_done`=1 on the cycle after STEP, in both cases.
- **DUMP.**
  - `o_pipe_en`=0 and `o_dbg_sel`=1 for the whole state.
  - `o_dump_valid`=1, `o_dump_addr`=`o_dbg_reg_addr`, `o_dump_data`=`i_reg_data`.
  - On each valid&ready handshake the address increments.
  - After the handshake at address `N_REGS`-1, the address returns to 0 and the state returns to the recorded return state (IDLE or HALTED).
  - `o_done` pulses on the first cycle back in that state.
  - The pipeline is frozen during DUMP, so data is stable while valid is 1 and ready is 0.
- **HALTED.** `o_pipe_en`=0.
  - DUMP goes to DUMP and records HALTED as the return state.
  - RUN, STEP and STOP are accepted and ignored.
  - HALTED is left only via reset.
- **Cycle counter.** Increments by 1 on every rising edge where `o_pipe_en`=1. It saturates at 2^N_BITS−1 and is never cleared except by reset.
- **Encoding.** Undefined state encodings recover to IDLE.

## Timing
- **Reset values.**
  - State IDLE, so `o_cmd_ready`=1.
  - `o_pipe_en`=0, `o_dbg_sel`=0, `o_dbg_reg_addr`=0.
  - `o_dump_valid`=0, `o_dump_addr`=0.
  - `o_done`=0, `o_cycle_count`=0.
- **Reset mid-operation.** Reset asserted mid-DUMP or mid-RUN aborts immediately and asynchronously; no `o_done` is generated.
- **Combinational outputs.** `o_pipe_en`, `o_dump_valid`, `o_dump_data` and `o_cmd_ready` are combinational from state and inputs. State, address, counter and `o_done` are registered.
- **Command latency.** An accepted command at edge k places the new state at edge k+1. RUN therefore advances the pipeline from the cycle after acceptance.
- **STEP.** Exactly one `o_pipe_en` cycle per STEP, unless halt is active in that cycle, in which case there are zero.
- **DUMP length.** With `i_dump_ready` held at 1, DUMP lasts exactly `N_REGS` cycles. Each cycle of ready=0 adds one cycle.

## Test plan
- **Reset values.** Assert reset low mid-cycle, asynchronously → all outputs take their reset values with no clock edge. `o_state`=0.
- **Run then halt.** RUN from IDLE; raise `i_halt` 10 cycles after `o_pipe_en` first rises → exactly 10 `o_pipe_en` cycles, `o_cycle_count`=10. `o_state`=4 from the next edge; a subsequent RUN is ignored.
- **Step.** STEP three times from IDLE, each after `o_done` → `o_cycle_count`=3, one `o_done` per step, and `o_cmd_ready`=0 during each STEP cycle.
- **Dump with backpressure.** DUMP from HALTED with `i_reg_data` = 0xA0000000+addr; toggle `i_dump_ready` 1,0,1,0… → 32 words, addr 0..31 in order, data stable while stalled. `o_done` once, return to HALTED, `o_pipe_en` never 1.
- **Simultaneous STOP and halt.** In RUN, STOP accepted in the same cycle as `i_halt`=1 → next state HALTED and `o_pipe_en`=0 in that cycle.
- **Reset mid-dump.** Assert reset during DUMP at addr 7 → state IDLE, `o_dbg_sel`=0, address 0, no `o_done` pulse.
